// File: rtl/reg_file_pkg.sv
// Shared register-file constants and write-request type, used by the
// write-port arbiter and later by the read-port arbiter.
package reg_file_pkg;

  localparam int REG_DATA_W = 16;
  localparam int REG_ADDR_W = 3;
  localparam int REG_NUM    = 2;

  // One requester's write: target register and the value to store.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rr_select.sv
// Round-robin winner search: finds the first set request at or after ptr,
// wrapping modulo NUM_REQ. Purely combinational so it can be shared by
// both register-file port arbiters.
module rr_select #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] eff_req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  int idx;

  // Walk the requests from ptr upward, taking the first active one.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!valid && eff_req[IDX_W'(idx)]) begin
        valid  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/reg_file_wr_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among
// NUM_REQ requesters. The winning write, its grant pulse and an error pulse
// for out-of-range addresses are registered one cycle after selection.
module reg_file_wr_arbiter
  import reg_file_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int NUM_REGS = REG_NUM,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int DATA_W   = REG_DATA_W,
  parameter int CNT_W    = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_in,
  input  logic [NUM_REQ*ADDR_W-1:0] waddr_in,
  input  logic [NUM_REQ*DATA_W-1:0] wdata_in,
  output logic [NUM_REQ-1:0]        gnt_out,
  output logic [NUM_REQ-1:0]        err_out,
  output logic                      r_d_wen_out,
  output logic [ADDR_W-1:0]         r_d_waddr_out,
  output logic [DATA_W-1:0]         d_out,
  output logic [CNT_W-1:0]          conflict_cnt_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] eff_req;
  logic [NUM_REQ-1:0] winner_onehot;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   winner;
  logic               valid;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               in_range;
  logic               contended;

  // A requester whose grant is currently visible sits out this cycle, giving
  // it time to drop or replace its request.
  assign eff_req = req_in & ~gnt_out;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .eff_req (eff_req),
    .ptr     (ptr),
    .winner  (winner),
    .valid   (valid)
  );

  assign sel_addr      = waddr_in[winner*ADDR_W +: ADDR_W];
  assign sel_data      = wdata_in[winner*DATA_W +: DATA_W];
  assign winner_onehot = NUM_REQ'(1) << winner;
  assign in_range      = int'(sel_addr) < NUM_REGS;
  assign contended     = $countones(eff_req) >= 2;

  // Register the selected write, grant/error pulses and rotate the pointer.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      gnt_out       <= '0;
      err_out       <= '0;
      r_d_wen_out   <= 1'b0;
      r_d_waddr_out <= '0;
      d_out         <= '0;
      ptr           <= '0;
    end else if (valid) begin
      gnt_out <= winner_onehot;
      ptr     <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      if (in_range) begin
        r_d_wen_out   <= 1'b1;
        r_d_waddr_out <= sel_addr;
        d_out         <= sel_data;
        err_out       <= '0;
      end else begin
        // Rejected write: address and data keep their last written values.
        r_d_wen_out <= 1'b0;
        err_out     <= winner_onehot;
      end
    end else begin
      gnt_out     <= '0;
      err_out     <= '0;
      r_d_wen_out <= 1'b0;
    end
  end

  // Saturating count of cycles with two or more live requests.
  always_ff @(posedge clock) begin
    if (reset) begin
      conflict_cnt_out <= '0;
    end else if (contended && (conflict_cnt_out != '1)) begin
      conflict_cnt_out <= conflict_cnt_out + 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// Directed bench for reg_file_wr_arbiter: single request, full contention,
// out-of-range rejection, idle hold, mid-operation reset and counter
// saturation (CNT_W = 4), with hand-computed expectations.
module tb_reg_file_wr_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 16;
  localparam int CNT_W   = 4;

  logic                      clock;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_in;
  logic [NUM_REQ*ADDR_W-1:0] waddr_in;
  logic [NUM_REQ*DATA_W-1:0] wdata_in;
  logic [NUM_REQ-1:0]        gnt_out;
  logic [NUM_REQ-1:0]        err_out;
  logic                      r_d_wen_out;
  logic [ADDR_W-1:0]         r_d_waddr_out;
  logic [DATA_W-1:0]         d_out;
  logic [CNT_W-1:0]          conflict_cnt_out;

  int errors = 0;
  int checks = 0;

  reg_file_wr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .NUM_REGS (2),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .CNT_W    (CNT_W)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .req_in           (req_in),
    .waddr_in         (waddr_in),
    .wdata_in         (wdata_in),
    .gnt_out          (gnt_out),
    .err_out          (err_out),
    .r_d_wen_out      (r_d_wen_out),
    .r_d_waddr_out    (r_d_waddr_out),
    .d_out            (d_out),
    .conflict_cnt_out (conflict_cnt_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] data);
    waddr_in[i*ADDR_W +: ADDR_W] = addr;
    wdata_in[i*DATA_W +: DATA_W] = data;
  endtask

  initial begin
    reset    = 1'b1;
    req_in   = '0;
    waddr_in = '0;
    wdata_in = '0;
    tick();
    tick();

    // Reset state.
    check("rst_gnt",   32'(gnt_out),          32'h0);
    check("rst_err",   32'(err_out),          32'h0);
    check("rst_wen",   32'(r_d_wen_out),      32'h0);
    check("rst_waddr", 32'(r_d_waddr_out),    32'h0);
    check("rst_data",  32'(d_out),            32'h0);
    check("rst_cnt",   32'(conflict_cnt_out), 32'h0);
    reset = 1'b0;

    // Single request from requester 1: granted from ptr 0, ptr becomes 2.
    set_req(0, 3'd0, 16'h1111);
    set_req(1, 3'd1, 16'hBEEF);
    set_req(2, 3'd0, 16'h3333);
    req_in = 3'b010;
    tick();
    check("single_gnt",   32'(gnt_out),          32'h2);
    check("single_err",   32'(err_out),          32'h0);
    check("single_wen",   32'(r_d_wen_out),      32'h1);
    check("single_waddr", 32'(r_d_waddr_out),    32'h1);
    check("single_data",  32'(d_out),            32'hBEEF);
    check("single_cnt",   32'(conflict_cnt_out), 32'h0);
    req_in = 3'b000;
    tick();
    check("drop_gnt",   32'(gnt_out),       32'h0);
    check("drop_wen",   32'(r_d_wen_out),   32'h0);
    check("drop_waddr", 32'(r_d_waddr_out), 32'h1);
    check("drop_data",  32'(d_out),         32'hBEEF);

    // All three request with ptr 2: requester 2 wins first, ptr wraps to 0.
    set_req(1, 3'd1, 16'h2222);
    req_in = 3'b111;
    tick();
    check("wrap_gnt",  32'(gnt_out),          32'h4);
    check("wrap_data", 32'(d_out),            32'h3333);
    check("wrap_cnt",  32'(conflict_cnt_out), 32'h1);

    // Held full contention from ptr 0: 001, 010, 100, 001; two live
    // requests remain every cycle, so the counter climbs each edge.
    tick();
    check("full0_gnt", 32'(gnt_out),          32'h1);
    check("full0_data", 32'(d_out),           32'h1111);
    check("full0_cnt", 32'(conflict_cnt_out), 32'h2);
    tick();
    check("full1_gnt", 32'(gnt_out),          32'h2);
    check("full1_data", 32'(d_out),           32'h2222);
    check("full1_cnt", 32'(conflict_cnt_out), 32'h3);
    tick();
    check("full2_gnt", 32'(gnt_out),          32'h4);
    check("full2_cnt", 32'(conflict_cnt_out), 32'h4);
    tick();
    check("full3_gnt", 32'(gnt_out),          32'h1);
    check("full3_data", 32'(d_out),           32'h1111);
    check("full3_cnt", 32'(conflict_cnt_out), 32'h5);
    req_in = 3'b000;
    tick();
    check("full_idle_gnt", 32'(gnt_out),          32'h0);
    check("full_idle_cnt", 32'(conflict_cnt_out), 32'h5);

    // Out-of-range address from requester 0 (ptr 1, wraps to 0).
    set_req(0, 3'd5, 16'hABCD);
    req_in = 3'b001;
    tick();
    check("oor_gnt",   32'(gnt_out),       32'h1);
    check("oor_err",   32'(err_out),       32'h1);
    check("oor_wen",   32'(r_d_wen_out),   32'h0);
    check("oor_waddr", 32'(r_d_waddr_out), 32'h0);
    check("oor_data",  32'(d_out),         32'h1111);
    req_in = 3'b000;
    tick();
    check("oor_clr_err", 32'(err_out), 32'h0);

    // Error grant advanced ptr to 1: with 0 and 2 requesting, 2 wins.
    set_req(0, 3'd0, 16'h1111);
    req_in = 3'b101;
    tick();
    check("oor_next_gnt",  32'(gnt_out),          32'h4);
    check("oor_next_err",  32'(err_out),          32'h0);
    check("oor_next_data", 32'(d_out),            32'h3333);
    check("oor_next_cnt",  32'(conflict_cnt_out), 32'h6);

    // Idle for five cycles: nothing granted, write path and counter hold.
    req_in = 3'b000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_gnt", 32'(gnt_out),     32'h0);
      check("idle_wen", 32'(r_d_wen_out), 32'h0);
    end
    check("idle_waddr", 32'(r_d_waddr_out),    32'h0);
    check("idle_data",  32'(d_out),            32'h3333);
    check("idle_cnt",   32'(conflict_cnt_out), 32'h6);

    // Reset mid-operation: grant requester 1 (ptr -> 2), then reset with
    // 1 and 2 still requesting; after release the search restarts at 0.
    req_in = 3'b010;
    tick();
    check("pre_rst_gnt", 32'(gnt_out), 32'h2);
    req_in = 3'b110;
    reset  = 1'b1;
    tick();
    check("mid_rst_gnt",  32'(gnt_out),          32'h0);
    check("mid_rst_wen",  32'(r_d_wen_out),      32'h0);
    check("mid_rst_data", 32'(d_out),            32'h0);
    check("mid_rst_cnt",  32'(conflict_cnt_out), 32'h0);
    reset = 1'b0;
    tick();
    check("post_rst_gnt",  32'(gnt_out),          32'h2);
    check("post_rst_data", 32'(d_out),            32'h2222);
    check("post_rst_cnt",  32'(conflict_cnt_out), 32'h1);

    // Saturation: with all three held, masking leaves two live requests
    // every cycle, so the 4-bit counter rises once per edge to 15 and stops.
    req_in = 3'b000;
    reset  = 1'b1;
    tick();
    reset  = 1'b0;
    req_in = 3'b111;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) check("sat_cnt14", 32'(conflict_cnt_out), 32'd14);
      if (i == 15) check("sat_cnt15", 32'(conflict_cnt_out), 32'd15);
    end
    check("sat_cnt20", 32'(conflict_cnt_out), 32'd15);
    // 20 grants from ptr 0 rotate 0,1,2,...: the 20th is requester 1.
    check("sat_gnt",   32'(gnt_out),          32'h2);
    req_in = 3'b000;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
